vga_layer_compositor: RTL and testbench

Parametrised frame compositor for the VGA output path: generates 640x480-style timing from the system clock, draws NUM_PIPES pipe sprites, the bird and a flat background with fixed priority, and outputs registered 12-bit RGB with matched sync. Game registers are latched into shadow copies once per frame, so no frame ever tears. Also reports per-frame bird/pipe pixel collision to the processor side.

---
 rtl/vga_layer_compositor.sv | 214 +++++++++++++++++++++
 tb/tb_vga_layer_compositor.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_layer_compositor.sv
// VGA layer compositor: raster timing, pipe/bird/background composition with
// fixed priority, once-per-frame shadow latching and bird/pipe collision flag.
// The reset input is asserted asynchronously; its release is expected to be
// synchronous to clk (driven from an upstream reset synchroniser).
module vga_layer_compositor #(
    parameter int          NUM_PIPES       = 4,
    parameter int          PIXEL_DIV       = 4,
    parameter int          H_ACTIVE        = 640,
    parameter int          H_FP            = 16,
    parameter int          H_SYNC          = 96,
    parameter int          H_BP            = 48,
    parameter int          V_ACTIVE        = 480,
    parameter int          V_FP            = 10,
    parameter int          V_SYNC          = 2,
    parameter int          V_BP            = 33,
    parameter int          PIPE_WIDTH      = 60,
    parameter int          PIPE_CAP_HEIGHT = 20,
    parameter int          GAP_HEIGHT      = 120,
    parameter int          BIRD_LEFT_EDGE  = 90,
    parameter int          BIRD_WIDTH      = 35,
    parameter int          BIRD_HEIGHT     = 35,
    parameter logic [11:0] BG_COLOR        = 12'h4CF,
    parameter logic [11:0] PIPE_COLOR      = 12'h2A2,
    parameter logic [11:0] CAP_COLOR       = 12'h171,
    parameter logic [11:0] BIRD_COLOR      = 12'hFE0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [32*NUM_PIPES-1:0]   pipe_regs,
    input  logic [31:0]               bird_reg,
    output logic                      hSync,
    output logic                      vSync,
    output logic [3:0]                VGA_R,
    output logic [3:0]                VGA_G,
    output logic [3:0]                VGA_B,
    output logic                      frame_done,
    output logic                      collision
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (PIXEL_DIV > 1) ? $clog2(PIXEL_DIV) : 1;

    typedef struct packed {
        logic       valid;
        logic [8:0] gap_top;
        logic [10:0] left;
    } pipe_t;

    // Returns {hit, cap} for one pipe at raster position (x, y).
    function automatic logic [1:0] pipe_hit(input pipe_t p, input logic [10:0] x, input logic [9:0] y);
        logic signed [11:0] left_s, right_s, x_s;
        logic [9:0]         gap_top, gap_end;
        logic               in_x, in_gap, in_cap, hit;
        left_s  = {p.left[10], p.left};
        right_s = left_s + $signed(12'(PIPE_WIDTH));
        x_s     = $signed({1'b0, x});
        in_x    = (x_s >= left_s) && (x_s < right_s);
        gap_top = {1'b0, p.gap_top};
        gap_end = gap_top + 10'(GAP_HEIGHT);
        in_gap  = (y >= gap_top) && (y < gap_end);
        // Upper cap written as y+CAP >= gap_top so a gap near the top never underflows.
        in_cap  = ((y + 10'(PIPE_CAP_HEIGHT) >= gap_top) && (y < gap_top)) ||
                  ((y >= gap_end) && (y < gap_end + 10'(PIPE_CAP_HEIGHT)));
        hit     = p.valid && in_x && !in_gap;
        return {hit, hit && in_cap};
    endfunction

    logic [DIV_W-1:0]        div_q, div_d;
    logic [10:0]             x_q, x_d;
    logic [9:0]              y_q, y_d;
    logic                    pix_tick, latch;

    pipe_t [NUM_PIPES-1:0]   pipe_in, pipe_sh_q;
    logic [8:0]              bird_sh_q;
    logic                    unused_bits;

    logic [NUM_PIPES-1:0]    pipe_hit_d, cap_hit_d;
    logic                    bird_hit_d, active_d, hs_raw_d, vs_raw_d;
    logic [NUM_PIPES-1:0]    s1_pipe_q, s1_cap_q;
    logic                    s1_bird_q, s1_active_q, s1_hs_q, s1_vs_q;

    logic [11:0]             rgb_d, rgb_q;
    logic                    hs_q, vs_q, acc_q, coll_q, frame_done_q;

    assign pix_tick = (div_q == DIV_W'(PIXEL_DIV - 1));
    assign latch    = pix_tick && (x_q == 11'(H_TOTAL - 1)) && (y_q == 10'(V_ACTIVE - 1));

    // Next-state for the pixel divider and raster counters.
    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        div_d = div_q + DIV_W'(1);
        x_d   = x_q;
        y_d   = y_q;
        if (pix_tick) begin
            div_d = '0;
            if (x_q == 11'(H_TOTAL - 1)) begin
                x_d = '0;
                y_d = (y_q == 10'(V_TOTAL - 1)) ? '0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 11'd1;
            end
        end
    end

    // Pixel divider and raster counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            div_q <= div_d;
            x_q   <= x_d;
            y_q   <= y_d;
        end
    end

    // Unpack pipe registers; fold the ignored register bits into a sink.
    always_comb begin
        unused_bits = ^bird_reg[31:9];
        for (int i = 0; i < NUM_PIPES; i++) begin
            pipe_in[i]  = '{valid:   pipe_regs[32*i+31],
                            gap_top: pipe_regs[32*i+11 +: 9],
                            left:    pipe_regs[32*i +: 11]};
            unused_bits = unused_bits ^ (^pipe_regs[32*i+20 +: 11]);
        end
    end

    // Frame latch: shadow copies, collision report and frame pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_sh_q    <= '0;
            bird_sh_q    <= '0;
            acc_q        <= 1'b0;
            coll_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= latch;
            if (latch) begin
                pipe_sh_q <= pipe_in;
                bird_sh_q <= bird_reg[8:0];
                coll_q    <= acc_q;
                acc_q     <= 1'b0;
            end else if (pix_tick && s1_active_q && s1_bird_q && (|s1_pipe_q)) begin
                acc_q <= 1'b1;
            end
        end
    end

    // Hit detection and raw timing for the current raster position.
    always_comb begin
        pipe_hit_d = '0;
        cap_hit_d  = '0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            {pipe_hit_d[i], cap_hit_d[i]} = pipe_hit(pipe_sh_q[i], x_q, y_q);
        end
        bird_hit_d = (x_q >= 11'(BIRD_LEFT_EDGE)) && (x_q < 11'(BIRD_LEFT_EDGE + BIRD_WIDTH)) &&
                     (y_q >= {1'b0, bird_sh_q}) && (y_q < {1'b0, bird_sh_q} + 10'(BIRD_HEIGHT));
        active_d   = (x_q < 11'(H_ACTIVE)) && (y_q < 10'(V_ACTIVE));
        hs_raw_d   = !((x_q >= 11'(H_ACTIVE + H_FP)) && (x_q < 11'(H_ACTIVE + H_FP + H_SYNC)));
        vs_raw_d   = !((y_q >= 10'(V_ACTIVE + V_FP)) && (y_q < 10'(V_ACTIVE + V_FP + V_SYNC)));
    end

    // Stage 1: register hit flags with matching active and sync.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_pipe_q   <= '0;
            s1_cap_q    <= '0;
            s1_bird_q   <= 1'b0;
            s1_active_q <= 1'b0;
            s1_hs_q     <= 1'b1;
            s1_vs_q     <= 1'b1;
        end else if (pix_tick) begin
            s1_pipe_q   <= pipe_hit_d;
            s1_cap_q    <= cap_hit_d;
            s1_bird_q   <= bird_hit_d;
            s1_active_q <= active_d;
            s1_hs_q     <= hs_raw_d;
            s1_vs_q     <= vs_raw_d;
        end
    end

    // Layer priority: lowest-index pipe over higher pipes over bird over background.
    always_comb begin
        rgb_d = BG_COLOR;
        if (s1_bird_q) rgb_d = BIRD_COLOR;
        for (int i = NUM_PIPES - 1; i >= 0; i--) begin
            if (s1_pipe_q[i]) rgb_d = s1_cap_q[i] ? CAP_COLOR : PIPE_COLOR;
        end
        if (!s1_active_q) rgb_d = 12'h000;
    end

    // Stage 2: registered colour and sync outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rgb_q <= 12'h000;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
        end else if (pix_tick) begin
            rgb_q <= rgb_d;
            hs_q  <= s1_hs_q;
            vs_q  <= s1_vs_q;
        end
    end

    assign {VGA_R, VGA_G, VGA_B} = rgb_q;
    assign hSync      = hs_q;
    assign vSync      = vs_q;
    assign frame_done = frame_done_q;
    assign collision  = coll_q;

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Self-checking bench for vga_layer_compositor: a reduced raster geometry keeps
// whole frames short; every clock the full output bundle is compared with a
// pixel-index reference model derived from clocks elapsed since reset release.
module tb_vga_layer_compositor;

    localparam int NP      = 4;
    localparam int DIV     = 2;
    localparam int H_ACT   = 64, H_FP = 4, H_SYNC = 8, H_BP = 4;
    localparam int V_ACT   = 40, V_FP = 2, V_SYNC = 2, V_BP = 6;
    localparam int PW      = 10, CAP = 3, GAP = 12;
    localparam int BL      = 20, BW = 6, BH = 6;
    localparam int H_TOT   = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOT   = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int FRAME   = H_TOT * V_TOT;       // pixels per frame
    localparam int FRAME_CLKS = FRAME * DIV;
    localparam int LATCH   = V_ACT * H_TOT;       // pixel index of (0, V_ACT)
    localparam logic [11:0] BG = 12'h4CF, PIPE = 12'h2A2, CAPC = 12'h171, BIRD = 12'hFE0;

    logic              clk, rst_n;
    logic [32*NP-1:0]  pipe_regs;
    logic [31:0]       bird_reg;
    logic              hSync, vSync, frame_done, collision;
    logic [3:0]        VGA_R, VGA_G, VGA_B;
    logic [15:0]       dut_out;

    int n_tests = 0, n_fail = 0;
    int fd_dut_cnt = 0, fd_model_cnt = 0;

    // Reference model state
    int               m_c;        // clock edges since reset release
    logic             m_coll;
    logic [32*NP-1:0] m_pipes;
    logic [31:0]      m_bird;

    vga_layer_compositor #(
        .NUM_PIPES(NP), .PIXEL_DIV(DIV),
        .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .PIPE_WIDTH(PW), .PIPE_CAP_HEIGHT(CAP), .GAP_HEIGHT(GAP),
        .BIRD_LEFT_EDGE(BL), .BIRD_WIDTH(BW), .BIRD_HEIGHT(BH)
    ) dut (
        .clk(clk), .reset(rst_n), .pipe_regs(pipe_regs), .bird_reg(bird_reg),
        .hSync(hSync), .vSync(vSync), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .frame_done(frame_done), .collision(collision)
    );

    assign dut_out = {frame_done, collision, hSync, vSync, VGA_R, VGA_G, VGA_B};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // 0 = outside pipe i, 1 = pipe body, 2 = pipe cap
    function automatic int pipe_region(int i, int x, int y);
        logic [31:0] r;
        int left, g;
        r    = m_pipes[32*i +: 32];
        left = int'($signed(r[10:0]));
        g    = int'(r[19:11]);
        if (!r[31]) return 0;
        if (x < left || x >= left + PW) return 0;
        if (y >= g && y < g + GAP) return 0;
        if ((y >= g - CAP && y < g) || (y >= g + GAP && y < g + GAP + CAP)) return 2;
        return 1;
    endfunction

    function automatic bit bird_at(int x, int y);
        int bt;
        bt = int'(m_bird[8:0]);
        return (x >= BL && x < BL + BW && y >= bt && y < bt + BH);
    endfunction

    // {hSync, vSync, rgb} the display must show for raster position (x, y)
    function automatic logic [13:0] exp_pixel(int x, int y);
        logic [11:0] rgb;
        logic        hs, vs;
        bit          found;
        int          reg_kind;
        hs  = !(x >= H_ACT + H_FP && x < H_ACT + H_FP + H_SYNC);
        vs  = !(y >= V_ACT + V_FP && y < V_ACT + V_FP + V_SYNC);
        rgb = 12'h000;
        if (x < H_ACT && y < V_ACT) begin
            found = 0;
            for (int i = 0; i < NP && !found; i++) begin
                reg_kind = pipe_region(i, x, y);
                if (reg_kind != 0) begin
                    found = 1;
                    rgb   = (reg_kind == 2) ? CAPC : PIPE;
                end
            end
            if (!found) rgb = bird_at(x, y) ? BIRD : BG;
        end
        return {hs, vs, rgb};
    endfunction

    // Does the bird overlap any pipe anywhere in the visible area?
    function automatic logic frame_overlap();
        for (int y = 0; y < V_ACT; y++)
            for (int x = 0; x < H_ACT; x++)
                if (bird_at(x, y))
                    for (int i = 0; i < NP; i++)
                        if (pipe_region(i, x, y) != 0) return 1'b1;
        return 1'b0;
    endfunction

    // Expected output bundle after m_c clock edges; display lags counters by 2 ticks.
    function automatic logic [15:0] exp_out();
        int   t, p, q;
        logic fd;
        t  = m_c / DIV;
        fd = (m_c > 0) && (m_c % DIV == 0) && (t % FRAME == LATCH);
        if (t < 2) return {fd, m_coll, 2'b11, 12'h000};
        p = t - 2;
        q = p % FRAME;
        return {fd, m_coll, exp_pixel(q % H_TOT, q / H_TOT)};
    endfunction

    // Model: clock count, shadow latch and per-frame collision.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_c     <= 0;
            m_coll  <= 1'b0;
            m_pipes <= '0;
            m_bird  <= '0;
        end else begin
            m_c <= m_c + 1;
            if (((m_c + 1) % DIV == 0) && (((m_c + 1) / DIV) % FRAME == LATCH)) begin
                m_coll       <= frame_overlap();
                m_pipes      <= pipe_regs;
                m_bird       <= bird_reg;
                fd_model_cnt <= fd_model_cnt + 1;
            end
        end
    end

    // Compare the whole output bundle every clock, away from the active edge.
    always @(negedge clk) begin
        check("out", {16'h0, dut_out}, {16'h0, exp_out()});
        if (frame_done) fd_dut_cnt++;
    end

    function automatic logic [31:0] mk_pipe(bit v, int gap, int left);
        return {v, 11'h000, 9'(gap), 11'(left)};
    endfunction

    function automatic logic [31:0] rand_pipe();
        logic [31:0] v;
        v        = $urandom;
        v[31]    = ($urandom_range(0, 9) < 7);
        v[19:11] = 9'($urandom_range(0, 36));
        v[10:0]  = 11'(int'($urandom_range(0, 90)) - 20);
        return v;
    endfunction

    initial begin
        int  r;
        bit  found;
        rst_n     = 1'b0;
        pipe_regs = '0;
        bird_reg  = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int f = 0; f < 6; f++) begin
            r = (f < 2) ? 1000 : int'($urandom_range(10, FRAME_CLKS - 10));
            repeat (r) @(negedge clk);
            if (f == 0) begin
                // Overlapping pipes 0 and 1 with the bird underneath both
                pipe_regs = {32'h0, 32'h0, mk_pipe(1, 20, 18), mk_pipe(1, 15, 15)};
                bird_reg  = 32'h0000_0005;
            end else if (f == 1) begin
                // Pipe hanging off the left edge, bird clear of it, junk in ignored bits
                pipe_regs = {32'h0, 32'h0, 32'h7FF0_0000, mk_pipe(1, 20, -5)};
                bird_reg  = 32'hABCD_E000 | 32'd30;
            end else begin
                for (int i = 0; i < NP; i++) pipe_regs[32*i +: 32] = rand_pipe();
                bird_reg       = $urandom;
                bird_reg[8:0]  = 9'($urandom_range(0, 38));
            end
            repeat (FRAME_CLKS - r) @(negedge clk);
            if (f == 1) check("coll_set", {31'h0, collision}, 32'd1);
            if (f == 2) check("coll_clear", {31'h0, collision}, 32'd0);
        end

        // Reset in the middle of the visible area
        found = 0;
        for (int k = 0; k < 2 * FRAME_CLKS; k++) begin
            if (((m_c / DIV) % FRAME) / H_TOT == 30) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check("row30_reached", {31'h0, found}, 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset", {16'h0, dut_out}, 32'h0000_3000);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (500) @(negedge clk);
        pipe_regs = {32'h0, mk_pipe(1, 10, 40), mk_pipe(1, 25, 18), mk_pipe(1, 2, 0)};
        bird_reg  = 32'd20;
        repeat (FRAME_CLKS + FRAME_CLKS / 2) @(negedge clk);

        check("frame_done_count", fd_dut_cnt, fd_model_cnt);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
